// File: rtl/e_mdu.sv
// E-stage multiply/divide unit for the 5-stage MIPS pipeline.
// Owns the architectural HI/LO registers.
// MULT/MULTU/DIV/DIVU compute their result in the start cycle. The result is held in
// pending registers and committed to HI/LO after a fixed busy countdown.
// MTHI/MTLO write HI/LO directly when the unit is idle.
// MFHI/MFLO are combinational reads of HI/LO.
module e_mdu #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] MDU_opA,
   input  logic [31:0] MDU_opB,
   input  logic [3:0]  MDU_op,
   input  logic        MDU_start,
   output logic        MDU_busy,
   output logic [31:0] MDU_HI,
   output logic [31:0] MDU_LO,
   output logic [31:0] MDU_result
);

   localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd5;
   localparam logic [3:0] OP_MTLO  = 4'd6;
   localparam logic [3:0] OP_MFHI  = 4'd7;
   localparam logic [3:0] OP_MFLO  = 4'd8;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [31:0]        hi_q, hi_d;
   logic [31:0]        lo_q, lo_d;
   logic [31:0]        pend_hi_q, pend_hi_d;
   logic [31:0]        pend_lo_q, pend_lo_d;
   logic               pend_wr_q, pend_wr_d;

   // Arithmetic results derived from the current operands
   logic               op_is_md_s;
   logic               op_is_div_s;
   logic [31:0]        res_hi_s;
   logic [31:0]        res_lo_s;
   logic               res_wr_s;
   logic [63:0]        prod_s;
   logic [31:0]        mag_a_s;
   logic [31:0]        mag_b_s;
   logic [31:0]        divisor_s;
   logic [31:0]        quo_s;
   logic [31:0]        rem_s;

   // Multiply and divide datapath; signed divide is done on magnitudes and re-signed,
   // which also makes 0x80000000 / -1 wrap to 0x80000000 with a zero remainder.
   always_comb begin
      op_is_md_s  = 1'b0;
      op_is_div_s = 1'b0;
      prod_s      = 64'd0;
      mag_a_s     = MDU_opA;
      mag_b_s     = MDU_opB;
      divisor_s   = 32'd1;
      quo_s       = 32'd0;
      rem_s       = 32'd0;
      res_hi_s    = 32'd0;
      res_lo_s    = 32'd0;
      res_wr_s    = 1'b0;
      case (MDU_op)
         OP_MULT: begin
            op_is_md_s = 1'b1;
            prod_s     = $signed({{32{MDU_opA[31]}}, MDU_opA}) * $signed({{32{MDU_opB[31]}}, MDU_opB});
            res_hi_s   = prod_s[63:32];
            res_lo_s   = prod_s[31:0];
            res_wr_s   = 1'b1;
         end
         OP_MULTU: begin
            op_is_md_s = 1'b1;
            prod_s     = {32'd0, MDU_opA} * {32'd0, MDU_opB};
            res_hi_s   = prod_s[63:32];
            res_lo_s   = prod_s[31:0];
            res_wr_s   = 1'b1;
         end
         OP_DIV, OP_DIVU: begin
            op_is_md_s  = 1'b1;
            op_is_div_s = 1'b1;
            if (MDU_op == OP_DIV) begin
               mag_a_s = MDU_opA[31] ? (32'd0 - MDU_opA) : MDU_opA;
               mag_b_s = MDU_opB[31] ? (32'd0 - MDU_opB) : MDU_opB;
            end else begin
               mag_a_s = MDU_opA;
               mag_b_s = MDU_opB;
            end
            // Divide by zero leaves HI/LO untouched; the divisor is forced to 1 only to keep the datapath defined
            divisor_s = (MDU_opB == 32'd0) ? 32'd1 : mag_b_s;
            quo_s     = mag_a_s / divisor_s;
            rem_s     = mag_a_s % divisor_s;
            if (MDU_op == OP_DIV) begin
               res_lo_s = (MDU_opA[31] ^ MDU_opB[31]) ? (32'd0 - quo_s) : quo_s;
               res_hi_s = MDU_opA[31] ? (32'd0 - rem_s) : rem_s;
            end else begin
               res_lo_s = quo_s;
               res_hi_s = rem_s;
            end
            res_wr_s = (MDU_opB != 32'd0);
         end
         default: begin
            op_is_md_s = 1'b0;
         end
      endcase
   end

   // Next-state logic for the IDLE/BUSY controller, the countdown and HI/LO
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      pend_hi_d = pend_hi_q;
      pend_lo_d = pend_lo_q;
      pend_wr_d = pend_wr_q;
      case (state_q)
         ST_IDLE: begin
            if (MDU_start && op_is_md_s) begin
               state_d   = ST_BUSY;
               cnt_d     = op_is_div_s ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
               pend_hi_d = res_hi_s;
               pend_lo_d = res_lo_s;
               pend_wr_d = res_wr_s;
            end else if (MDU_op == OP_MTHI) begin
               hi_d = MDU_opA;
            end else if (MDU_op == OP_MTLO) begin
               lo_d = MDU_opA;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_BUSY: begin
            if (cnt_q == CNT_W'(1)) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               if (pend_wr_q) begin
                  hi_d = pend_hi_q;
                  lo_d = pend_lo_q;
               end else begin
                  hi_d = hi_q;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Controller state and architectural registers; reset aborts any operation in flight
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         hi_q      <= 32'd0;
         lo_q      <= 32'd0;
         pend_hi_q <= 32'd0;
         pend_lo_q <= 32'd0;
         pend_wr_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         pend_hi_q <= pend_hi_d;
         pend_lo_q <= pend_lo_d;
         pend_wr_q <= pend_wr_d;
      end
   end

   // MFHI/MFLO read mux feeding the shared E-stage result mux
   always_comb begin
      case (MDU_op)
         OP_MFHI: MDU_result = hi_q;
         OP_MFLO: MDU_result = lo_q;
         default: MDU_result = 32'd0;
      endcase
   end

   assign MDU_busy = MDU_start | (state_q == ST_BUSY);
   assign MDU_HI   = hi_q;
   assign MDU_LO   = lo_q;

endmodule

// File: tb/tb_e_mdu.sv
// Directed self-checking bench for e_mdu (MULT_CYCLES=5, DIV_CYCLES=10).
module tb_e_mdu;

   logic        clk;
   logic        reset;
   logic [31:0] MDU_opA;
   logic [31:0] MDU_opB;
   logic [3:0]  MDU_op;
   logic        MDU_start;
   logic        MDU_busy;
   logic [31:0] MDU_HI;
   logic [31:0] MDU_LO;
   logic [31:0] MDU_result;

   int pass_cnt  = 0;
   int check_cnt = 0;

   e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk        (clk),
      .reset      (reset),
      .MDU_opA    (MDU_opA),
      .MDU_opB    (MDU_opB),
      .MDU_op     (MDU_op),
      .MDU_start  (MDU_start),
      .MDU_busy   (MDU_busy),
      .MDU_HI     (MDU_HI),
      .MDU_LO     (MDU_LO),
      .MDU_result (MDU_result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      check_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // advance to 2 time units after the next rising edge
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // launch op in the current cycle T; returns in cycle T+1 with the start dropped
   task automatic launch(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      MDU_op    = op;
      MDU_opA   = a;
      MDU_opB   = b;
      MDU_start = 1'b1;
      #1;
      chk("busy_start", {31'd0, MDU_busy}, 32'd1);
      step();
      MDU_start = 1'b0;
      MDU_op    = 4'd0;
      MDU_opA   = 32'd0;
      MDU_opB   = 32'd0;
   endtask

   // check busy over cycles T+1..T+n, leaving the bench in cycle T+n+1 with busy low
   task automatic wait_busy(input int n, input logic [31:0] old_lo);
      for (int i = 1; i <= n; i++) begin
         #1;
         chk("busy_run", {31'd0, MDU_busy}, 32'd1);
         if (i == n) chk("lo_held", MDU_LO, old_lo);
         step();
      end
      #1;
      chk("busy_done", {31'd0, MDU_busy}, 32'd0);
   endtask

   initial begin
      reset     = 1'b0;
      MDU_opA   = 32'd0;
      MDU_opB   = 32'd0;
      MDU_op    = 4'd0;
      MDU_start = 1'b0;
      #12;
      chk("rst_hi", MDU_HI, 32'd0);
      chk("rst_lo", MDU_LO, 32'd0);
      chk("rst_busy", {31'd0, MDU_busy}, 32'd0);
      chk("rst_result", MDU_result, 32'd0);
      MDU_start = 1'b1;
      #1;
      chk("rst_busy_start", {31'd0, MDU_busy}, 32'd1);
      MDU_start = 1'b0;
      step();
      reset = 1'b1;
      step();

      // 1: MULT -2 * 3
      launch(4'd1, 32'hFFFFFFFE, 32'd3);
      wait_busy(5, 32'd0);
      chk("mult_hi", MDU_HI, 32'hFFFFFFFF);
      chk("mult_lo", MDU_LO, 32'hFFFFFFFA);

      // 2: MULTU max * max, then MFHI/MFLO reads
      launch(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
      wait_busy(5, 32'hFFFFFFFA);
      chk("multu_hi", MDU_HI, 32'hFFFFFFFE);
      chk("multu_lo", MDU_LO, 32'h00000001);
      MDU_op = 4'd7;
      #1;
      chk("mfhi", MDU_result, 32'hFFFFFFFE);
      MDU_op = 4'd8;
      #1;
      chk("mflo", MDU_result, 32'h00000001);
      MDU_op = 4'd0;
      #1;
      chk("nop_result", MDU_result, 32'd0);
      step();

      // 3: DIV -7 / 2, DIVU 7 / 2, DIV overflow case
      launch(4'd3, 32'hFFFFFFF9, 32'd2);
      wait_busy(10, 32'h00000001);
      chk("div_lo", MDU_LO, 32'hFFFFFFFD);
      chk("div_hi", MDU_HI, 32'hFFFFFFFF);
      launch(4'd4, 32'd7, 32'd2);
      wait_busy(10, 32'hFFFFFFFD);
      chk("divu_lo", MDU_LO, 32'd3);
      chk("divu_hi", MDU_HI, 32'd1);
      launch(4'd3, 32'h80000000, 32'hFFFFFFFF);
      wait_busy(10, 32'd3);
      chk("divovf_lo", MDU_LO, 32'h80000000);
      chk("divovf_hi", MDU_HI, 32'd0);

      // 4: MTHI then divide by zero
      MDU_op  = 4'd5;
      MDU_opA = 32'h12345678;
      #1;
      chk("mthi_busy", {31'd0, MDU_busy}, 32'd0);
      step();
      MDU_op  = 4'd0;
      MDU_opA = 32'd0;
      #1;
      chk("mthi_hi", MDU_HI, 32'h12345678);
      launch(4'd3, 32'd99, 32'd0);
      wait_busy(10, 32'h80000000);
      chk("div0_hi", MDU_HI, 32'h12345678);
      chk("div0_lo", MDU_LO, 32'h80000000);

      // 5: MULT 6*7 with ignored DIVU start at T+2 and ignored MTHI at T+3
      launch(4'd1, 32'd6, 32'd7);                       // now T+1
      step();                                            // T+2
      MDU_op    = 4'd4;
      MDU_opA   = 32'd100;
      MDU_opB   = 32'd3;
      MDU_start = 1'b1;
      step();                                            // T+3
      MDU_start = 1'b0;
      MDU_op    = 4'd5;
      MDU_opA   = 32'hDEADBEEF;
      step();                                            // T+4
      MDU_op    = 4'd0;
      MDU_opA   = 32'd0;
      #1;
      chk("ign_hi_mid", MDU_HI, 32'h12345678);
      chk("ign_busy_t4", {31'd0, MDU_busy}, 32'd1);
      step();                                            // T+5
      #1;
      chk("ign_lo_t5", MDU_LO, 32'h80000000);
      step();                                            // T+6
      #1;
      chk("ign_busy_t6", {31'd0, MDU_busy}, 32'd0);
      chk("ign_mult_hi", MDU_HI, 32'd0);
      chk("ign_mult_lo", MDU_LO, 32'h0000002A);
      step();
      #1;
      chk("ign_no_restart", {31'd0, MDU_busy}, 32'd0);
      MDU_op  = 4'd6;
      MDU_opA = 32'hA5A5A5A5;
      #1;
      chk("mtlo_busy", {31'd0, MDU_busy}, 32'd0);
      step();
      MDU_op  = 4'd0;
      MDU_opA = 32'd0;
      #1;
      chk("mtlo_lo", MDU_LO, 32'hA5A5A5A5);
      chk("mtlo_hi", MDU_HI, 32'd0);

      // 6: DIV aborted by reset at T+4
      MDU_op  = 4'd5;
      MDU_opA = 32'h0BADF00D;
      step();
      MDU_op  = 4'd0;
      MDU_opA = 32'd0;
      launch(4'd3, 32'd100, 32'd7);                      // now T+1
      step();                                            // T+2
      step();                                            // T+3
      step();                                            // T+4
      reset = 1'b0;
      #1;
      chk("abort_hi", MDU_HI, 32'd0);
      chk("abort_lo", MDU_LO, 32'd0);
      chk("abort_busy", {31'd0, MDU_busy}, 32'd0);
      step();                                            // T+5
      reset = 1'b1;
      for (int i = 0; i < 9; i++) step();                // T+14
      #1;
      chk("late_hi", MDU_HI, 32'd0);
      chk("late_lo", MDU_LO, 32'd0);
      chk("late_busy", {31'd0, MDU_busy}, 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
